store_occupancy_counter: RTL
============================

Name: store_occupancy_counter

Overview:
- Clocked, parametrised occupancy counter for the smart-store entrance subsystem.
- Each door has an entry pressure pad and an exit pressure pad. Every raw pad input is synchronised and debounced, then reduced to a single-cycle event on its press edge.
- All door events are summed into a saturating occupancy count, which drives full/empty status and sticky error flags to the store controller.

Parameters:
- NUM_DOORS, 2, number of doors; each door has one entry pad and one exit pad.
- CNT_W, 8, width of the occupancy count.
- MAX_OCC, 100, store capacity; the count saturates here. Constraint: MAX_OCC <= 2**CNT_W-1.
- DEBOUNCE_CYC, 4, consecutive stable synchronised cycles needed to change a pad's debounced state. Constraint: >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- pad_in  input  NUM_DOORS  raw entry pads, asynchronous, active-high.
- pad_out  input  NUM_DOORS  raw exit pads, asynchronous, active-high.
- clear_err  input  1  synchronous clear of the sticky error flags.
- count  output  CNT_W  current occupancy.
- full  output  1  high when count == MAX_OCC.
- empty  output  1  high when count == 0.
- overflow_err  output  1  sticky; an update tried to exceed MAX_OCC.
- underflow_err  output  1  sticky; an update tried to go below 0.
- peak_count  output  CNT_W  present only with STORE_PEAK_TRACK_EN.

Behaviour:
- Reset:
  - count=0, empty=1, full=0, overflow_err=0, underflow_err=0, peak_count=0.
  - All synchroniser flops, debounced states and debounce counters are cleared.
  - Reset overrides every other input in the same cycle, including mid-debounce and mid-event.
- Synchroniser: two flops per pad (2*NUM_DOORS pads in total).
- Debounce, per pad, on the synchroniser output s and the debounced state d:
  - if s==d: the debounce counter is set to 0.
  - else if counter==DEBOUNCE_CYC-1: d<=s and the counter is set to 0.
  - else: counter+1.
  - Any glitch shorter than DEBOUNCE_CYC synchronised cycles produces no event.
- Event: a one-cycle pulse when d goes 0->1 (d & ~d_prev). Holding a pad high gives exactly one event; release generates nothing.
- Latency: if a raw pad is first sampled high at edge N and stays high, count updates at edge N+DEBOUNCE_CYC+2 (N+6 with the defaults).
- Per-cycle arithmetic:
  - inc = number of entry events; dec = number of exit events. Both are 0..NUM_DOORS.
  - Compute next = count + inc - dec in signed width CNT_W+2.
  - If next > MAX_OCC: count<=MAX_OCC and overflow_err<=1.
  - If next < 0: count<=0 and underflow_err<=1.
  - Otherwise count<=next.
- Simultaneous events:
  - All doors are processed in the same cycle.
  - Entry and exit events in the same cycle, on the same or different doors, cancel arithmetically before saturation. Example: count=MAX_OCC with +1 and -1 gives MAX_OCC and no error.
- full and empty are decoded combinationally from the count register, so they stay consistent with count every cycle.
- clear_err clears both sticky flags at the next edge. If a new over/underflow happens in the same cycle, set wins.
- No wrap-around is allowed under any input sequence.

Optional Feature:
- Macro: STORE_PEAK_TRACK_EN.
- Defined:
  - peak_count port exists and holds the maximum count reached since reset.
  - peak_count updates on the same edge as count, so after any edge where count > peak_count, peak_count equals count.
  - clear_err does not affect peak_count.
- Undefined: the peak_count port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset, then pad_in[0] held high for 10 cycles -> count goes 0->1 exactly at edge N+6, only one increment; empty drops to 0 in the same cycle.
- pad_in[1] glitch high for 3 cycles (DEBOUNCE_CYC=4) -> count is unchanged; no event.
- Preload to 99, then pad_in[0] and pad_in[1] events in the same cycle -> count=100, full=1, overflow_err=1. Then clear_err -> overflow_err=0 and count stays 100.
- count=0, pad_out[0] event -> count stays 0, underflow_err=1, empty=1. Then an entry event on door 0 and an exit event on door 1 in the same cycle at count=5 -> count stays 5.
- Reset asserted in the same cycle as an event pulse at count=7 -> count=0, flags 0, debounce state cleared. A pad held high through the reset release gives one event 6 cycles after the release.
- With STORE_PEAK_TRACK_EN: run the count 0->3->1 -> peak_count=3. After reset, peak_count=0. Without the macro the bench builds with no peak_count port.

Source files
------------

// File: rtl/store_occupancy_counter.sv
// Smart-store entrance occupancy counter: per-pad sync/debounce/edge-detect feeding a saturating count.
// Optional peak tracking (peak_count port) is enabled by defining STORE_PEAK_TRACK_EN.
module store_occupancy_counter #(
  parameter int unsigned NUM_DOORS    = 2,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned MAX_OCC      = 100,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DOORS-1:0] pad_in,
  input  logic [NUM_DOORS-1:0] pad_out,
  input  logic                 clear_err,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow_err,
  output logic                 underflow_err
`ifdef STORE_PEAK_TRACK_EN
  ,
  output logic [CNT_W-1:0]     peak_count
`endif
);

  localparam int unsigned NP = 2 * NUM_DOORS;
  localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0]          DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0]       MAX_C   = CNT_W'(MAX_OCC);
  localparam logic signed [CNT_W+1:0] MAX_S  = (CNT_W+2)'(MAX_OCC);

  // Entry pads occupy the low half, exit pads the high half.
  logic [NP-1:0] raw, sync1, sync2, deb, deb_prev, ev;
  logic [DW-1:0] dcnt [NP];

  assign raw = {pad_out, pad_in};
  assign ev  = deb & ~deb_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int unsigned i = 0; i < NP; i++) dcnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      for (int unsigned i = 0; i < NP; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_LAST) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  logic signed [CNT_W+1:0] inc, dec, nxt;
  logic [CNT_W-1:0]        count_d;
  logic                    over, under;

  // Entries and exits cancel before saturation is applied.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < NUM_DOORS; i++) begin
      inc = inc + (CNT_W+2)'(ev[i]);
      dec = dec + (CNT_W+2)'(ev[NUM_DOORS+i]);
    end
    nxt   = $signed({2'b00, count}) + inc - dec;
    over  = (nxt > MAX_S);
    under = nxt[CNT_W+1];
    if (over)       count_d = MAX_C;
    else if (under) count_d = '0;
    else            count_d = nxt[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      count <= count_d;
      // A new error in the same cycle as clear_err wins.
      if (clear_err) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end
      if (over)  overflow_err  <= 1'b1;
      if (under) underflow_err <= 1'b1;
    end
  end

  assign full  = (count == MAX_C);
  assign empty = (count == '0);

`ifdef STORE_PEAK_TRACK_EN
  always_ff @(posedge clk) begin
    if (reset)                    peak_count <= '0;
    else if (count_d > peak_count) peak_count <= count_d;
  end
`endif

endmodule
